// File: rtl/pacman_pkg.sv
`default_nettype none
// =============================================================================
// pacman_pkg : shared direction codes, maze geometry and wall map.
// Revision   : 1.0
// =============================================================================
package pacman_pkg;

    // One-hot {up,down,left,right}; zero means no direction / stopped.
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam int MAZE_ROWS = 8;
    localparam int MAZE_COLS = 8;

    // Bit index row*8+col, cell (0,0) is bit 0 of this [0:63] vector (the MSB).
    localparam logic [0:63] DEFAULT_WALL_MAP = 64'hFF87B781BDBD81FF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } mover_state_e;

    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        case (dir)
            DIR_UP:    opposite_dir = DIR_DOWN;
            DIR_DOWN:  opposite_dir = DIR_UP;
            DIR_LEFT:  opposite_dir = DIR_RIGHT;
            DIR_RIGHT: opposite_dir = DIR_LEFT;
            default:   opposite_dir = DIR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_mover_wall_lookup.sv
`default_nettype none
// =============================================================================
// maze_wall_lookup : reports whether the neighbour cell in a direction is a wall.
// Revision         : 1.0
// =============================================================================
module maze_wall_lookup
    import pacman_pkg::*;
#(
    parameter logic [0:63] WALL_MAP = DEFAULT_WALL_MAP
) (
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [3:0] direction,
    output logic       blocked
);

    logic [2:0] nrow;
    logic [2:0] ncol;
    logic       in_bounds;

    always_comb begin
        nrow      = row;
        ncol      = col;
        in_bounds = 1'b0;
        case (direction)
            DIR_UP: if (row != 3'd0) begin
                nrow      = row - 3'd1;
                in_bounds = 1'b1;
            end
            DIR_DOWN: if (row != 3'(MAZE_ROWS - 1)) begin
                nrow      = row + 3'd1;
                in_bounds = 1'b1;
            end
            DIR_LEFT: if (col != 3'd0) begin
                ncol      = col - 3'd1;
                in_bounds = 1'b1;
            end
            DIR_RIGHT: if (col != 3'(MAZE_COLS - 1)) begin
                ncol      = col + 3'd1;
                in_bounds = 1'b1;
            end
            default: in_bounds = 1'b0;
        endcase
        // No direction or off-grid neighbour both read as blocked.
        blocked = in_bounds ? WALL_MAP[{nrow, ncol}] : 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/pacman_mover.sv
`default_nettype none
// =============================================================================
// pacman_mover : Pac-Man position/heading register with buffered turn requests.
// Revision     : 1.0
// =============================================================================
module pacman_mover
    import pacman_pkg::*;
#(
    parameter int          CELL_PX   = 32,
    parameter int          STEP_PX   = 2,
    parameter int          ORIGIN_X  = 192,
    parameter int          ORIGIN_Y  = 112,
    parameter int          START_ROW = 1,
    parameter int          START_COL = 1,
    parameter logic [0:63] WALL_MAP  = DEFAULT_WALL_MAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_tick,
    input  logic       game_en,
    input  logic [3:0] dir_req,
    output logic [9:0] pm_xpos,
    output logic [9:0] pm_ypos,
    output logic [3:0] pm_direction,
    output logic [2:0] pm_row,
    output logic [2:0] pm_col,
    output logic       at_centre
);

    localparam logic [9:0] CELL_W  = 10'(CELL_PX);
    localparam logic [9:0] HALF_W  = 10'(CELL_PX / 2);
    localparam logic [9:0] STEP_W  = 10'(STEP_PX);
    localparam logic [9:0] ORG_X_W = 10'(ORIGIN_X);
    localparam logic [9:0] ORG_Y_W = 10'(ORIGIN_Y);
    localparam logic [9:0] RESET_X = 10'(ORIGIN_X + START_COL * CELL_PX + CELL_PX / 2);
    localparam logic [9:0] RESET_Y = 10'(ORIGIN_Y + START_ROW * CELL_PX + CELL_PX / 2);

    logic [9:0]   xpos_q, xpos_d;
    logic [9:0]   ypos_q, ypos_d;
    logic [3:0]   dir_q, dir_d;
    logic [3:0]   pending_q, pending_d;
    mover_state_e state_q, state_d;

    logic [9:0] x_off;
    logic [9:0] y_off;
    logic       centre;
    logic       pend_blocked;
    logic       cur_blocked;
    logic       req_valid;
    logic       step;

    assign x_off     = xpos_q - ORG_X_W;
    assign y_off     = ypos_q - ORG_Y_W;
    assign pm_col    = 3'(x_off / CELL_W);
    assign pm_row    = 3'(y_off / CELL_W);
    assign centre    = ((x_off % CELL_W) == HALF_W) && ((y_off % CELL_W) == HALF_W);
    assign at_centre = centre;

    assign pm_xpos      = xpos_q;
    assign pm_ypos      = ypos_q;
    assign pm_direction = dir_q;

    // Exactly one bit set: non-zero and no second bit left after clearing the lowest.
    assign req_valid = (dir_req != DIR_NONE) && ((dir_req & (dir_req - 4'd1)) == 4'd0);

    maze_wall_lookup #(.WALL_MAP(WALL_MAP)) u_pend_lookup (
        .row       (pm_row),
        .col       (pm_col),
        .direction (pending_q),
        .blocked   (pend_blocked)
    );

    maze_wall_lookup #(.WALL_MAP(WALL_MAP)) u_cur_lookup (
        .row       (pm_row),
        .col       (pm_col),
        .direction (dir_q),
        .blocked   (cur_blocked)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        step      = 1'b0;

        if (move_tick && game_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!pend_blocked) begin
                        dir_d     = pending_q;
                        pending_d = DIR_NONE;
                        state_d   = ST_MOVE;
                        step      = 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (centre) begin
                        if (!pend_blocked) begin
                            dir_d     = pending_q;
                            pending_d = DIR_NONE;
                            step      = 1'b1;
                        end else if (!cur_blocked) begin
                            step = 1'b1;
                        end else begin
                            dir_d   = DIR_NONE;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Between centres only an exact reversal may be taken early.
                        if ((pending_q != DIR_NONE) && (pending_q == opposite_dir(dir_q))) begin
                            dir_d     = pending_q;
                            pending_d = DIR_NONE;
                        end
                        step = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A fresh request wins over the clear caused by adoption in the same cycle.
        if (req_valid) begin
            pending_d = dir_req;
        end

        if (step) begin
            case (dir_d)
                DIR_UP:    ypos_d = ypos_q - STEP_W;
                DIR_DOWN:  ypos_d = ypos_q + STEP_W;
                DIR_LEFT:  xpos_d = xpos_q - STEP_W;
                DIR_RIGHT: xpos_d = xpos_q + STEP_W;
                default:   xpos_d = xpos_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_q    <= RESET_X;
            ypos_q    <= RESET_Y;
            dir_q     <= DIR_NONE;
            pending_q <= DIR_NONE;
            state_q   <= ST_IDLE;
        end else begin
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pacman_mover.sv
`default_nettype none
// =============================================================================
// tb_pacman_mover : directed self-checking bench for pacman_mover.
// Revision        : 1.0
// =============================================================================
module tb_pacman_mover;

    logic       clk;
    logic       rst_n;
    logic       move_tick;
    logic       game_en;
    logic [3:0] dir_req;
    logic [9:0] pm_xpos;
    logic [9:0] pm_ypos;
    logic [3:0] pm_direction;
    logic [2:0] pm_row;
    logic [2:0] pm_col;
    logic       at_centre;

    int n_checks;
    int n_fail;

    // Observed status packed as {x, y, dir, row, col, centre}.
    logic [30:0] obs;
    logic [30:0] exp_v;
    assign obs = {pm_xpos, pm_ypos, pm_direction, pm_row, pm_col, at_centre};

    pacman_mover dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .move_tick    (move_tick),
        .game_en      (game_en),
        .dir_req      (dir_req),
        .pm_xpos      (pm_xpos),
        .pm_ypos      (pm_ypos),
        .pm_direction (pm_direction),
        .pm_row       (pm_row),
        .pm_col       (pm_col),
        .at_centre    (at_centre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        move_tick = 1'b0;
        game_en   = 1'b1;
        dir_req   = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] d);
        @(negedge clk);
        dir_req = d;
        @(negedge clk);
        dir_req = 4'b0000;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = {10'd240, 10'd160, 4'b0000, 3'd1, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_wall_stop();
        do_reset();
        req(4'b1000);
        tick(5);
        exp_v = {10'd240, 10'd160, 4'b0000, 3'd1, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL up_into_wall: got %h expected %h", obs, exp_v);
        end
        req(4'b0001);
        tick(1);
        exp_v = {10'd242, 10'd160, 4'b0001, 3'd1, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL right_first_step: got %h expected %h", obs, exp_v);
        end
        tick(47);
        exp_v = {10'd336, 10'd160, 4'b0001, 3'd1, 3'd4, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL right_48_ticks: got %h expected %h", obs, exp_v);
        end
        tick(1);
        exp_v = {10'd336, 10'd160, 4'b0000, 3'd1, 3'd4, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL right_wall_stop: got %h expected %h", obs, exp_v);
        end
        tick(2);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_stays_stopped: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_turn_at_centre();
        do_reset();
        req(4'b0100);
        tick(10);
        req(4'b0001);
        tick(6);
        exp_v = {10'd240, 10'd192, 4'b0100, 3'd2, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL down_tick16: got %h expected %h", obs, exp_v);
        end
        tick(1);
        exp_v = {10'd240, 10'd194, 4'b0100, 3'd2, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL blocked_turn_continues: got %h expected %h", obs, exp_v);
        end
        tick(15);
        exp_v = {10'd240, 10'd224, 4'b0100, 3'd3, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL down_tick32: got %h expected %h", obs, exp_v);
        end
        tick(1);
        exp_v = {10'd242, 10'd224, 4'b0001, 3'd3, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL turn_right_tick33: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        req(4'b0001);
        tick(5);
        exp_v = {10'd250, 10'd160, 4'b0001, 3'd1, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rev_before: got %h expected %h", obs, exp_v);
        end
        req(4'b0010);
        tick(1);
        exp_v = {10'd248, 10'd160, 4'b0010, 3'd1, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rev_after: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_ignore_and_freeze();
        do_reset();
        req(4'b0101);
        tick(3);
        exp_v = {10'd240, 10'd160, 4'b0000, 3'd1, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL multibit_ignored: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        game_en = 1'b0;
        req(4'b0001);
        tick(4);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL disabled_idle_frozen: got %h expected %h", obs, exp_v);
        end
        game_en = 1'b1;
        tick(1);
        exp_v = {10'd242, 10'd160, 4'b0001, 3'd1, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL latched_while_disabled: got %h expected %h", obs, exp_v);
        end
        game_en = 1'b0;
        tick(3);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL disabled_midcell_frozen: got %h expected %h", obs, exp_v);
        end
        game_en = 1'b1;
        tick(1);
        exp_v = {10'd244, 10'd160, 4'b0001, 3'd1, 3'd1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL resume_after_enable: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req(4'b0001);
        tick(5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_v = {10'd240, 10'd160, 4'b0000, 3'd1, 3'd1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_midcell: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_cleared_pending: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        move_tick = 1'b0;
        game_en   = 1'b1;
        dir_req   = 4'b0000;
        test_reset();
        test_wall_stop();
        test_turn_at_centre();
        test_reversal();
        test_ignore_and_freeze();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
